// File: rtl/mux_pkg.sv
// Shared select codes and select type for the three-input datapath mux.
package mux_pkg;

    typedef logic [1:0] sel3_t;

    localparam sel3_t SEL_IN0 = 2'd0;
    localparam sel3_t SEL_IN1 = 2'd1;
    localparam sel3_t SEL_IN2 = 2'd2;
    localparam sel3_t SEL_BAD = 2'd3;

endpackage : mux_pkg

// File: rtl/out_reg.sv
// Registered copy of the mux output plus the select-error flag.
// Asynchronous active-low reset clears both immediately.
module out_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_d_i,
    input  logic             err_d_i,
    output logic [WIDTH-1:0] data_q_o,
    output logic             err_q_o
);

    logic [WIDTH-1:0] data_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d_i;
            err_q  <= err_d_i;
        end
    end

    assign data_q_o = data_q;
    assign err_q_o  = err_q;

endmodule : out_reg

// File: rtl/three_mux_32.sv
// 32-bit three-input select mux: zero-latency Out, plus a registered
// copy and a flag for the illegal select code.
module three_mux_32
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  sel3_t            Sel,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Out_q,
    output logic             SelErr
);

    logic sel_err_c;

    // Illegal code drives zeros; an unknown select propagates X in simulation.
    always_comb begin
        Out = '0;
        case (Sel)
            SEL_IN0: Out = In0;
            SEL_IN1: Out = In1;
            SEL_IN2: Out = In2;
            SEL_BAD: Out = '0;
            default: Out = 'x;
        endcase
    end

    assign sel_err_c = (Sel == SEL_BAD);

    out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_d_i (Out),
        .err_d_i  (sel_err_c),
        .data_q_o (Out_q),
        .err_q_o  (SelErr)
    );

endmodule : three_mux_32

// File: tb/tb_three_mux_32.sv
// Self-checking bench for three_mux_32: directed steps then randomized
// traffic against a behavioural model of the select and its registered copy.
module tb_three_mux_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] in0, in1, in2;
    logic [1:0]  sel;
    logic [31:0] out_w, out_q_w;
    logic        sel_err_w;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_q;
    logic        mdl_err;

    three_mux_32 #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .In0    (in0),
        .In1    (in1),
        .In2    (in2),
        .Sel    (sel),
        .Out    (out_w),
        .Out_q  (out_q_w),
        .SelErr (sel_err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick one of three inputs by index, anything else yields zero.
    function automatic logic [31:0] ref_out(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
        logic [31:0] tbl [3];
        tbl[0] = a;
        tbl[1] = b;
        tbl[2] = c;
        if (int'(s) < 3) return tbl[int'(s)];
        return 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        check(tag, out_w, ref_out(sel, in0, in1, in2));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_q"}, out_q_w, mdl_q);
        check({tag, "_err"}, 32'(sel_err_w), 32'(mdl_err));
    endtask

    // Advance one rising edge, updating the model with the pre-edge values.
    task automatic tick();
        if (rst_n) begin
            mdl_q   = ref_out(sel, in0, in1, in2);
            mdl_err = (sel == 2'd3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        sel = s;
        in0 = a;
        in1 = b;
        in2 = c;
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        mdl_q   = 32'h0;
        mdl_err = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 32'h0);
        check_comb("rst_out");
        check_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_regs("post_rst");

        drive(2'd0, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
        check("sel0_out", out_w, 32'hAAAAAAAA);
        tick();
        check("sel0_q", out_q_w, 32'hAAAAAAAA);
        check_regs("sel0");

        drive(2'd1, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
        check("sel1_out", out_w, 32'hBBBBBBBB);
        check("sel1_lag", out_q_w, 32'hAAAAAAAA);
        tick();
        check_regs("sel1");

        drive(2'd2, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
        check("sel2_out", out_w, 32'hCCCCCCCC);
        tick();
        check_regs("sel2");

        drive(2'd3, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
        check("sel3_out", out_w, 32'h0);
        tick();
        check("sel3_err", 32'(sel_err_w), 32'h1);
        check("sel3_q", out_q_w, 32'h0);

        drive(2'd1, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
        tick();
        check("rec_err", 32'(sel_err_w), 32'h0);
        check("rec_q", out_q_w, 32'hBBBBBBBB);

        drive(2'd2, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h12345678);
        check("trk1_out", out_w, 32'h12345678);
        tick();
        drive(2'd2, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hFFFFFFFF);
        check("trk2_out", out_w, 32'hFFFFFFFF);
        check("trk2_hold", out_q_w, 32'h12345678);
        tick();
        check("trk2_q", out_q_w, 32'hFFFFFFFF);

        drive(2'd2, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
        tick();
        check("pre_rst_q", out_q_w, 32'hCCCCCCCC);
        rst_n = 1'b0;
        #1;
        check("async_rst_q", out_q_w, 32'h0);
        check("async_rst_err", 32'(sel_err_w), 32'h0);
        check("async_rst_out", out_w, 32'hCCCCCCCC);
        rst_n = 1'b1;
        mdl_q   = 32'h0;
        mdl_err = 1'b0;
        #1;
        check_regs("rst_release");
        tick();
        check_regs("after_release");

        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            check_comb("rnd_out");
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                #1;
                mdl_q   = 32'h0;
                mdl_err = 1'b0;
                check_regs("rnd_rst");
                rst_n = 1'b1;
            end
            tick();
            check_regs("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_three_mux_32

// File: doc/three_mux_32.md
Name: three_mux_32

Overview:
- 32-bit three-input select multiplexer for the multicycle CPU datapath, e.g. ALU-result / ALUOut / jump-target selection into PC, or register-file write-data selection.
- Combinational output `Out` drives the datapath with zero latency.
- A registered copy `Out_q` and a select-error flag `SelErr` are provided for pipelined consumers and debug.
- One clock domain; the asynchronous active-low reset clears only the registered state.

Parameters:
- WIDTH, 32, data width of In0/In1/In2/Out/Out_q.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- rst_n  input  1  reset, asynchronous, active-low.
- In0  input  WIDTH  data input selected when Sel=2'd0.
- In1  input  WIDTH  data input selected when Sel=2'd1.
- In2  input  WIDTH  data input selected when Sel=2'd2.
- Sel  input  2  select code.
- Out  output  WIDTH  combinational mux output.
- Out_q  output  WIDTH  Out registered on the rising edge of clk.
- SelErr  output  1  registered flag; 1 when Sel was 2'd3 at the last clock edge.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Out is purely combinational, with no clock or reset dependency:
  - Sel=0 -> In0; Sel=1 -> In1; Sel=2 -> In2.
  - Sel=3 (illegal) -> all zeros.
  - Sel containing X/Z -> Out is X in simulation; no latch is inferred.
- Out changes within the same delta as any change on In0/In1/In2/Sel. Latency 0.
- Registered path:
  - While rst_n=0: Out_q=0 and SelErr=0 immediately, independent of clk.
  - Deasserting rst_n does nothing until the next rising clk.
  - On each rising clk with rst_n=1: Out_q <= Out (the value just before the edge), and SelErr <= (Sel==2'd3).
  - Out_q therefore lags Out by exactly one cycle.
- Reset asserted mid-operation: registered outputs clear immediately. Out keeps tracking its inputs.
- No handshake and no enable: every cycle captures.
- Width rule: all data paths are exactly WIDTH bits; no sign or zero extension is performed inside the block.
- Simultaneous Sel and data change in one cycle: Out reflects both immediately. Out_q captures the combined result at the next edge.

Decomposition:
- Shared package mux_pkg:
  - SEL_IN0=2'd0, SEL_IN1=2'd1, SEL_IN2=2'd2, SEL_BAD=2'd3.
  - typedef sel3_t = logic [1:0].
- Sub-module out_reg (WIDTH-bit async-active-low-reset register) holds Out_q and SelErr.
- The combinational select stays in the top level.

Test Plan:
- rst_n=0, all inputs 0 -> Out=0, Out_q=0, SelErr=0. Release rst_n, clock once -> unchanged.
- In0=AAAAAAAA, In1=BBBBBBBB, In2=CCCCCCCC, Sel=0 -> Out=AAAAAAAA at once; Out_q=AAAAAAAA after the next rising clk.
- Same inputs, Sel=1 -> Out=BBBBBBBB. Sel=2 -> Out=CCCCCCCC. Out_q follows one cycle later in each case.
- Sel=3 with the same inputs -> Out=00000000 immediately. After a clk edge: SelErr=1 and Out_q=0. Then Sel=1 plus one clk -> SelErr=0, Out_q=BBBBBBBB.
- Sel=2, In2 changed 12345678->FFFFFFFF between edges -> Out tracks each value immediately; Out_q holds 12345678 until the next edge.
- rst_n pulsed low between edges while Out_q=CCCCCCCC -> Out_q=0 and SelErr=0 without a clock edge; Out stays CCCCCCCC.
